counter_intr_axil_slave: RTL and testbench

COUNTER_INTR_AXIL_SLAVE -- requirements
Module: counter_intr_axil_slave

---
 rtl/counter_intr_pkg.sv | 19 +
 rtl/counter_intr_core.sv | 48 ++++
 rtl/counter_intr_axil_slave.sv | 139 +++++++++++++
 tb/tb_counter_intr_axil_slave.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_intr_pkg.sv
// Shared constants for the counter/interrupt AXI4-Lite slave: register
// byte offsets, CTRL bit positions and AXI response codes.
package counter_intr_pkg;

    localparam logic [31:0] OFF_GIE   = 32'h00;
    localparam logic [31:0] OFF_IER   = 32'h04;
    localparam logic [31:0] OFF_ISR   = 32'h08;
    localparam logic [31:0] OFF_IAR   = 32'h0C;
    localparam logic [31:0] OFF_IPR   = 32'h10;
    localparam logic [31:0] OFF_CTRL  = 32'h14;
    localparam logic [31:0] OFF_LIMIT = 32'h18;
    localparam logic [31:0] OFF_COUNT = 32'h1C;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/counter_intr_core.sv
// Free-running counter with compare limit. Raises evt for the cycle in which
// an enabled COUNT equals LIMIT; software writes take priority over hardware.
module counter_intr_core
    import counter_intr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_we,
    input  logic [1:0]  ctrl_wdata,
    input  logic        limit_we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [1:0]  ctrl,
    output logic [31:0] limit,
    output logic [31:0] count,
    output logic        evt
);

    assign evt = ctrl[CTRL_EN] && (count == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl  <= '0;
            limit <= '0;
            count <= '0;
        end else begin
            if (evt) begin
                count <= '0;
                if (!ctrl[CTRL_AUTORELOAD])
                    ctrl[CTRL_EN] <= 1'b0;
            end else if (ctrl[CTRL_EN]) begin
                count <= count + 32'd1;
            end

            if (ctrl_we)
                ctrl <= ctrl_wdata;

            // Any accepted LIMIT write restarts the count, even with no byte lanes set
            if (limit_we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b])
                        limit[8*b +: 8] <= wdata[8*b +: 8];
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/counter_intr_axil_slave.sv
// AXI4-Lite register slave wrapping the limit counter with a GIE/IER/ISR
// interrupt block and a registered level irq output.
module counter_intr_axil_slave
    import counter_intr_pkg::*;
#(
    parameter int C_IRQ_ACTIVE_HIGH = 1,
    parameter int C_ADDR_WIDTH      = 5
)(
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [C_ADDR_WIDTH-1:0] AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [C_ADDR_WIDTH-1:0] ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    irq
);

    logic        unused_prot;
    logic [31:0] wr_off, rd_off, rd_word;
    logic        wr_fire, rd_fire;
    logic        gie, ier, isr, irq_q;
    logic        gie_we, ier_we, ctrl_we, limit_we, iar_clr;
    logic [1:0]  ctrl;
    logic [31:0] limit, count;
    logic        evt;

    assign unused_prot = ^{AWPROT, ARPROT};

    // Byte address bits [1:0] never select a register
    assign wr_off = 32'(AWADDR) & 32'hFFFF_FFFC;
    assign rd_off = 32'(ARADDR) & 32'hFFFF_FFFC;

    assign wr_fire = AWREADY && AWVALID && WVALID;
    assign rd_fire = ARREADY && ARVALID;

    assign gie_we   = wr_fire && (wr_off == OFF_GIE)   && WSTRB[0];
    assign ier_we   = wr_fire && (wr_off == OFF_IER)   && WSTRB[0];
    assign ctrl_we  = wr_fire && (wr_off == OFF_CTRL)  && WSTRB[0];
    assign limit_we = wr_fire && (wr_off == OFF_LIMIT);
    assign iar_clr  = wr_fire && (wr_off == OFF_IAR)   && WSTRB[0] && WDATA[0];

    assign BRESP = RESP_OKAY;
    assign RRESP = RESP_OKAY;

    counter_intr_core u_core (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .ctrl_we    (ctrl_we),
        .ctrl_wdata (WDATA[1:0]),
        .limit_we   (limit_we),
        .wdata      (WDATA),
        .wstrb      (WSTRB),
        .ctrl       (ctrl),
        .limit      (limit),
        .count      (count),
        .evt        (evt)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
        end else begin
            AWREADY <= !AWREADY && AWVALID && WVALID && !BVALID;
            WREADY  <= !AWREADY && AWVALID && WVALID && !BVALID;
            if (wr_fire)
                BVALID <= 1'b1;
            else if (BREADY)
                BVALID <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gie   <= 1'b0;
            ier   <= 1'b0;
            isr   <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (gie_we) gie <= WDATA[0];
            if (ier_we) ier <= WDATA[0];
            // A counter event in the same cycle as an ack keeps the status set
            if (evt)
                isr <= 1'b1;
            else if (iar_clr)
                isr <= 1'b0;
            irq_q <= gie && isr && ier;
        end
    end

    assign irq = (C_IRQ_ACTIVE_HIGH != 0) ? irq_q : !irq_q;

    always_comb begin
        rd_word = '0;
        case (rd_off)
            OFF_GIE:   rd_word = {31'b0, gie};
            OFF_IER:   rd_word = {31'b0, ier};
            OFF_ISR:   rd_word = {31'b0, isr};
            OFF_IPR:   rd_word = {31'b0, isr & ier};
            OFF_CTRL:  rd_word = {30'b0, ctrl};
            OFF_LIMIT: rd_word = limit;
            OFF_COUNT: rd_word = count;
            default:   rd_word = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
        end else begin
            ARREADY <= !ARREADY && ARVALID && !RVALID;
            if (rd_fire) begin
                RVALID <= 1'b1;
                RDATA  <= rd_word;
            end else if (RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_counter_intr_axil_slave.sv
// Directed bench for counter_intr_axil_slave; 6-bit address window so that
// offset 0x20 is a genuinely unmapped location.
module tb_counter_intr_axil_slave;

    localparam int AW = 6;
    localparam logic [AW-1:0] A_GIE = 6'h00, A_IER = 6'h04, A_ISR = 6'h08, A_IAR = 6'h0C,
                              A_IPR = 6'h10, A_CTRL = 6'h14, A_LIMIT = 6'h18, A_COUNT = 6'h1C,
                              A_UNMAP = 6'h20;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [AW-1:0] AWADDR;
    logic [2:0]    AWPROT;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    counter_intr_axil_slave #(.C_IRQ_ACTIVE_HIGH(1), .C_ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
        chk("wr_awready_seen", AWREADY, 1'b1);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
        chk("wr_bvalid_seen", BVALID, 1'b1);
        chk("wr_bresp", BRESP, 2'b00);
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
        int n;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
        chk("rd_arready_seen", ARREADY, 1'b1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("rd_rvalid", RVALID, 1'b1);
        chk("rd_rresp", RRESP, 2'b00);
        d = RDATA;
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(a, v);
        chk(tag, v, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int n, pulses, distinct;
        logic [31:0] prev;

        ARESETN = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
        ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
        #1;
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_irq", irq, 0);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        rd_chk("rst_limit", A_LIMIT, 0);
        rd_chk("rst_count", A_COUNT, 0);

        // Basic auto-reload counting and interrupt assertion
        axi_write(A_GIE, 1, 4'hF);
        axi_write(A_IER, 1, 4'hF);
        axi_write(A_LIMIT, 9, 4'hF);
        axi_write(A_CTRL, 3, 4'hF);
        n = 0;
        while (!irq && n < 15) begin @(negedge ACLK); n++; end
        chk("irq_assert", irq, 1);
        rd_chk("ipr_pending", A_IPR, 1);
        distinct = 0;
        prev = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            axi_read(A_COUNT, v);
            chk("count_range", v <= 9, 1);
            if (v != prev) distinct++;
            prev = v;
        end
        chk("count_moving", distinct > 1, 1);

        // One-shot: event clears EN; then acknowledge
        axi_write(A_CTRL, 1, 4'hF);
        repeat (15) @(negedge ACLK);
        chk("irq_before_ack", irq, 1);
        axi_write(A_IAR, 1, 4'hF);
        chk("irq_after_ack", irq, 0);
        rd_chk("ipr_after_ack", A_IPR, 0);
        rd_chk("isr_after_ack", A_ISR, 0);
        rd_chk("ctrl_oneshot", A_CTRL, 0);
        rd_chk("count_hold_a", A_COUNT, 0);
        rd_chk("count_hold_b", A_COUNT, 0);

        // LIMIT=0 with EN: event every cycle beats an ack
        axi_write(A_LIMIT, 0, 4'hF);
        axi_write(A_CTRL, 3, 4'hF);
        repeat (3) @(negedge ACLK);
        chk("irq_limit0", irq, 1);
        axi_write(A_IAR, 1, 4'hF);
        rd_chk("isr_set_wins", A_ISR, 1);
        chk("irq_set_wins", irq, 1);
        axi_write(A_CTRL, 0, 4'hF);
        axi_write(A_IAR, 1, 4'hF);
        rd_chk("isr_cleared", A_ISR, 0);

        // Byte strobes, unmapped and write-only offsets
        axi_write(A_LIMIT, 32'hA5A5_A5A5, 4'h3);
        rd_chk("limit_strb", A_LIMIT, 32'h0000_A5A5);
        axi_write(A_COUNT, 32'h1234, 4'hF);
        rd_chk("count_ro", A_COUNT, 0);
        rd_chk("unmapped_rd", A_UNMAP, 0);
        rd_chk("iar_reads0", A_IAR, 0);
        axi_write(A_GIE, 0, 4'h0);
        rd_chk("gie_strb0", A_GIE, 1);
        rd_chk("addr_lowbits", 6'h07, 1);

        // Write response back-pressure with a second write waiting
        @(negedge ACLK);
        AWADDR = A_GIE; WDATA = 1; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
        n = 0;
        while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
        chk("stall_aw_seen", AWREADY, 1);
        @(negedge ACLK);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_bvalid", BVALID, 1);
            if (AWREADY || WREADY) pulses++;
            @(negedge ACLK);
        end
        chk("stall_no_awready", pulses, 0);
        AWVALID = 0; WVALID = 0; BREADY = 1;
        chk("stall_bvalid_end", BVALID, 1);
        @(negedge ACLK);
        BREADY = 0;
        chk("stall_bvalid_drop", BVALID, 0);

        // Read response back-pressure
        @(negedge ACLK);
        ARADDR = A_LIMIT; ARVALID = 1; RREADY = 0;
        n = 0;
        while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
        chk("rstall_ar_seen", ARREADY, 1);
        @(negedge ACLK);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            chk("rstall_rvalid", RVALID, 1);
            chk("rstall_rdata", RDATA, 32'h0000_A5A5);
            if (ARREADY) pulses++;
            @(negedge ACLK);
        end
        chk("rstall_no_arready", pulses, 0);
        ARVALID = 0; RREADY = 1;
        @(negedge ACLK);
        RREADY = 0;
        chk("rstall_rvalid_drop", RVALID, 0);

        // Reset while a write response is pending and irq is asserted
        axi_write(A_LIMIT, 0, 4'hF);
        axi_write(A_CTRL, 1, 4'hF);
        repeat (3) @(negedge ACLK);
        chk("pre_rst_irq", irq, 1);
        @(negedge ACLK);
        AWADDR = A_IER; WDATA = 1; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
        n = 0;
        while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        chk("pre_rst_bvalid", BVALID, 1);
        #2 ARESETN = 1'b0;
        #1;
        chk("rst_async_bvalid", BVALID, 0);
        chk("rst_async_irq", irq, 0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        BREADY = 1;
        repeat (3) @(negedge ACLK);
        chk("post_rst_bvalid", BVALID, 0);
        chk("post_rst_rvalid", RVALID, 0);
        BREADY = 0;
        rd_chk("post_rst_gie", A_GIE, 0);
        rd_chk("post_rst_ier", A_IER, 0);
        rd_chk("post_rst_isr", A_ISR, 0);
        rd_chk("post_rst_ipr", A_IPR, 0);
        rd_chk("post_rst_ctrl", A_CTRL, 0);
        rd_chk("post_rst_limit", A_LIMIT, 0);
        rd_chk("post_rst_count", A_COUNT, 0);
        chk("post_rst_irq", irq, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
